// File: rtl/bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bit_serial_subtractor
//
// Purpose:
//   Sequential WIDTH-bit subtractor computing D = A - B - Bin (mod 2^WIDTH).
//   It processes one bit per clock, LSB first, through a single full-subtractor
//   cell whose borrow is held in a register. Valid/ready handshakes are used on
//   both the operand side and the result side.
//
// Optional feature (macro SUB_OVERFLOW_EN):
//   When defined, the borrow into the MSB cell is kept, and V is registered
//   as borrow_into_msb ^ Bout (two's-complement overflow of A - B - Bin).
//   When undefined, V is tied to 0 and the extra register does not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous, active-low reset
//   in_valid   in   operands A/B/Bin valid
//   in_ready   out  block can accept operands (state IDLE)
//   A          in   [WIDTH-1:0] minuend
//   B          in   [WIDTH-1:0] subtrahend
//   Bin        in   borrow in
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer accepts result
//   D          out  [WIDTH-1:0] difference
//   Bout       out  borrow out (A < B + Bin, unsigned)
//   V          out  signed overflow (0 unless SUB_OVERFLOW_EN)
// -----------------------------------------------------------------------------
module bit_serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;       // minuend, shifted right so bit 0 is current
   logic [WIDTH-1:0] b_q, b_d;       // subtrahend, shifted the same way
   logic [WIDTH-1:0] res_q, res_d;   // partial result, filled from the MSB side
   logic             br_q, br_d;     // running borrow
   logic [CW-1:0]    cnt_q, cnt_d;   // index of the bit being processed
   logic [WIDTH-1:0] dout_q, dout_d; // presented result, held until next result
   logic             bout_q, bout_d;

   // Full-subtractor cell
   logic diff_bit;
   logic borrow_nxt;

   assign diff_bit   = a_q[0] ^ b_q[0] ^ br_q;
   assign borrow_nxt = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

`ifdef SUB_OVERFLOW_EN
   logic v_q, v_d;
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      br_d      = br_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      bout_d    = bout_q;
`ifdef SUB_OVERFLOW_EN
      v_d       = v_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = borrow_nxt;
            res_d = {diff_bit, res_q[WIDTH-1:1]};
            if (cnt_q == CNT_LAST) begin
               // Final bit: publish the completed word. The counter is left
               // at its last value so it never wraps.
               dout_d  = {diff_bit, res_q[WIDTH-1:1]};
               bout_d  = borrow_nxt;
`ifdef SUB_OVERFLOW_EN
               // br_q here is the borrow into the MSB cell.
               v_d     = br_q ^ borrow_nxt;
`endif
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            // in_valid is deliberately ignored here, even alongside out_ready.
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         dout_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         bout_q  <= bout_d;
`ifdef SUB_OVERFLOW_EN
         v_q     <= v_d;
`endif
      end
   end

   assign D    = dout_q;
   assign Bout = bout_q;
`ifdef SUB_OVERFLOW_EN
   assign V    = v_q;
`else
   assign V    = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_subtractor
//
// Self-checking bench for bit_serial_subtractor. Two instances (WIDTH=4 and
// WIDTH=8) share one clock. The expected difference, borrow and overflow come
// from plain integer arithmetic on A - B - Bin.
// -----------------------------------------------------------------------------
module tb_bit_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit done8    = 1'b0;

   // ---------------- WIDTH = 4 instance ----------------
   logic       rst_n4, in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0] A4, B4, D4;
   logic       Bin4, Bout4, V4;

   bit_serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
      .A(A4), .B(B4), .Bin(Bin4), .out_valid(out_valid4), .out_ready(out_ready4),
      .D(D4), .Bout(Bout4), .V(V4)
   );

   // ---------------- WIDTH = 8 instance ----------------
   logic       rst_n8, in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0] A8, B8, D8;
   logic       Bin8, Bout8, V8;

   bit_serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
      .A(A8), .B(B8), .Bin(Bin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .D(D8), .Bout(Bout8), .V(V8)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: unsigned difference, borrow and signed overflow of a - b - bin.
   function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                   output int d, output int bo, output int v);
      int diff, sa, sb, r;
      diff = a - b - bin;
      bo   = (diff < 0) ? 1 : 0;
      d    = diff & ((1 << w) - 1);
      sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      r    = sa - sb - bin;
`ifdef SUB_OVERFLOW_EN
      v    = ((r < -(1 << (w - 1))) || (r >= (1 << (w - 1)))) ? 1 : 0;
`else
      v    = 0;
`endif
   endfunction

   // One WIDTH=4 transaction. hold>0 keeps out_ready low for that many cycles
   // of DONE while in_valid is pulsed, then releases it together with in_valid.
   task automatic txn4(input int a, input int b, input int bin, input int hold);
      int d, bo, v, n;
      ref_sub(4, a, b, bin, d, bo, v);
      @(negedge clk);
      check("rdy4", int'(in_ready4), 1);
      out_ready4 = (hold == 0);
      A4 = a[3:0]; B4 = b[3:0]; Bin4 = bin[0]; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      A4 = 4'($urandom); B4 = 4'($urandom); Bin4 = 1'($urandom);
      n = 0;
      while (!out_valid4 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("lat4", n, 4);
      check("D4", int'(D4), d);
      check("Bout4", int'(Bout4), bo);
      check("V4", int'(V4), v);
      $display("W4 A=%0h B=%0h Bin=%0d -> D=%0h Bout=%0d V=%0d", a, b, bin, D4, Bout4, V4);
      for (int i = 0; i < hold; i++) begin
         in_valid4 = 1'b1;
         A4 = 4'($urandom); B4 = 4'($urandom); Bin4 = 1'($urandom);
         @(negedge clk);
         check("bp_D4", int'(D4), d);
         check("bp_Bout4", int'(Bout4), bo);
         check("bp_valid4", int'(out_valid4), 1);
         check("bp_rdy4", int'(in_ready4), 0);
      end
      if (hold > 0) begin
         // out_ready and in_valid together in DONE: only the output completes.
         out_ready4 = 1'b1;
         in_valid4  = 1'b1;
         @(negedge clk);
         check("rel_valid4", int'(out_valid4), 0);
         check("rel_rdy4", int'(in_ready4), 1);
         in_valid4 = 1'b0;
      end
   endtask

   task automatic txn8(input int a, input int b, input int bin);
      int d, bo, v, n;
      ref_sub(8, a, b, bin, d, bo, v);
      @(negedge clk);
      A8 = a[7:0]; B8 = b[7:0]; Bin8 = bin[0]; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      A8 = 8'($urandom); B8 = 8'($urandom); Bin8 = 1'($urandom);
      n = 0;
      while (!out_valid8 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("lat8", n, 8);
      check("D8", int'(D8), d);
      check("Bout8", int'(Bout8), bo);
      check("V8", int'(V8), v);
   endtask

   // WIDTH=8 stream
   initial begin
      rst_n8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
      A8 = '0; B8 = '0; Bin8 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy8", int'(in_ready8), 1);
      check("rst_valid8", int'(out_valid8), 0);
      check("rst_D8", int'(D8), 0);
      rst_n8 = 1'b1;
      txn8(0, 0, 1);
      txn8(255, 255, 0);
      txn8(128, 1, 0);
      for (int i = 0; i < 1000; i++)
         txn8(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
      $display("W8 random stream complete");
      done8 = 1'b1;
   end

   // WIDTH=4 directed + random, then summary
   initial begin
      rst_n4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
      A4 = '0; B4 = '0; Bin4 = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy4", int'(in_ready4), 1);
      check("rst_valid4", int'(out_valid4), 0);
      check("rst_D4", int'(D4), 0);
      check("rst_Bout4", int'(Bout4), 0);
      check("rst_V4", int'(V4), 0);
      rst_n4 = 1'b1;

      txn4(9, 3, 0, 0);
      txn4(3, 9, 0, 0);
      txn4(0, 0, 1, 0);
      txn4(15, 15, 0, 0);
      txn4(8, 1, 0, 0);
      txn4(7, 15, 0, 0);

      // Reset after bits 0 and 1 of 5 - 2 have been processed.
      @(negedge clk);
      A4 = 4'd5; B4 = 4'd2; Bin4 = 1'b0; in_valid4 = 1'b1;
      @(negedge clk);
      in_valid4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n4 = 1'b0;
      @(negedge clk);
      rst_n4 = 1'b1;
      check("mid_rdy4", int'(in_ready4), 1);
      check("mid_valid4", int'(out_valid4), 0);
      check("mid_D4", int'(D4), 0);
      check("mid_Bout4", int'(Bout4), 0);
      check("mid_V4", int'(V4), 0);
      $display("W4 reset mid-RUN: D=%0h Bout=%0d in_ready=%0d", D4, Bout4, in_ready4);
      txn4(5, 2, 0, 0);

      txn4(12, 5, 1, 5);
      txn4(6, 6, 1, 0);

      for (int i = 0; i < 1000; i++)
         txn4(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)), 0);

      wait (done8);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
